cam_rgb444_capture: RTL and testbench
=====================================

Name: cam_rgb444_capture

Overview:
- Upstream stage of the chroma-key path.
- Assembles OV7670 RGB565 byte pairs into RGB444 pixels and writes them into the frame buffer.
- The frame buffer is later read out as the red_mem/green_mem/blue_mem foreground pixels.
- Runs in the camera pixel-clock domain, tracks VSYNC/HREF framing and generates linear write addresses for an H_ACT x V_ACT image.

Parameters:
- H_ACT, 320: active pixels per line stored.
- V_ACT, 240: active lines per frame stored.
- ADDR_W, 17: write-address width; must satisfy 2^ADDR_W >= H_ACT*V_ACT.

Ports:
- clk  in  1  camera pixel clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cam_vsync  in  1  camera VSYNC; high = vertical blanking.
- cam_href  in  1  camera HREF; high = valid bytes on cam_data.
- cam_data  in  8  camera byte bus; first byte = RGB565[15:8], second byte = RGB565[7:0].
- mem_we  out  1  frame-buffer write strobe, one cycle per pixel.
- mem_addr  out  ADDR_W  linear pixel address, line*H_ACT + pixel.
- mem_wdata  out  12  {R[3:0],G[3:0],B[3:0]}.
- frame_done  out  1  one-cycle pulse at the end of each completed frame.
- frame_err  out  1  sticky flag: a frame was aborted or was short; cleared only by reset.

Behaviour:
- Reset (reset_n low at a clk edge): all outputs 0, FSM to S_WAIT_VS, counters 0, byte phase 0. Reset mid-line discards any partial pixel.
- Inputs cam_vsync, cam_href and cam_data are registered once. All decisions use the registered copies.
- FSM states:
  - S_WAIT_VS: wait for registered vsync high, then go to S_BLANK.
  - S_BLANK: on a vsync falling edge, clear line_cnt, pix_cnt and phase, then go to S_ACTIVE.
  - S_ACTIVE: capture pixels.
    - Vsync rising with line_cnt == V_ACT: pulse frame_done, go to S_BLANK.
    - Vsync rising with line_cnt < V_ACT: set frame_err, no frame_done, go to S_BLANK.
- Byte pairing (S_ACTIVE, href high):
  - phase 0: latch cam_data into the high byte, phase becomes 1.
  - phase 1: form the 16-bit word, phase becomes 0, issue a write.
- Pixel conversion: mem_wdata = {d[15:12], d[10:7], d[4:1]} (top 4 bits of each RGB565 field).
- Write timing: mem_we, mem_addr and mem_wdata are registered outputs, asserted the cycle after the second byte is sampled internally.
  - Total latency from the second byte at the pins to mem_we: 2 clk.
  - mem_addr = line_cnt*H_ACT + pix_cnt, kept as a running address register. No multiplier.
- Write suppression: writes happen only while pix_cnt < H_ACT and line_cnt < V_ACT. Excess pixels and lines are dropped silently, and the address never exceeds H_ACT*V_ACT-1.
- Href falling edge in S_ACTIVE:
  - If at least one pixel was seen on the line, line_cnt increments (saturating at V_ACT).
  - pix_cnt clears; the running address moves to the start of the next line (line_cnt*H_ACT), so short lines leave a gap and do not shift later lines.
  - phase resets to 0, and a dangling odd byte is discarded.
- Href high while vsync is high is ignored.
- Simultaneous href fall and vsync rise: process the line end first, then check the frame end in the same cycle.
- mem_we is low in every cycle it is not written. frame_done and mem_we never assert in the same cycle.

Optional Feature:
- CAPTURE_FREEZE_EN defined: adds input port freeze (1 bit).
  - freeze is sampled only at a vsync falling edge (frame start).
  - If freeze = 1, that whole frame runs with mem_we held 0; framing, frame_done and frame_err still operate.
  - A freeze change mid-frame has no effect until the next frame start.
- Undefined: no freeze port; every frame is written.

Decomposition:
- Package cam_capture_pkg: state enum (S_WAIT_VS, S_BLANK, S_ACTIVE), RGB565 bit-field index constants, and the function rgb565_to_444.
- Sub-module cam_sync_edge: registers vsync/href/data and produces the vsync_rise, vsync_fall and href_fall pulses.
- FSM, counters and write port stay in the top module.

Test Plan:
- Reset, then one frame of 4 lines x 8 pixels (H_ACT=8, V_ACT=4), bytes 0xF8,0x00 per pixel -> 32 writes, addresses 0..31, mem_wdata=0xF00, then a single frame_done.
- Pixel bytes 0x07,0xE0 -> mem_wdata=0x0F0. Bytes 0x00,0x1F -> 0x00F. mem_we exactly 2 clk after the second byte.
- Line of 10 pixels with H_ACT=8 -> 8 writes (addr 0..7); next line starts at addr 8; no out-of-range address.
- Line of 5 pixels plus an odd trailing byte -> 5 writes; next line starts at addr 8; the odd byte is not written.
- Vsync rises after 2 of 4 lines -> no frame_done, frame_err=1. Next full frame writes from addr 0 and frame_err stays 1.
- reset_n low mid-line -> mem_we=0, outputs 0 on the next edge; capture restarts only after a full vsync high->low sequence.

Source files
------------

// File: rtl/cam_rgb444_capture_pkg.sv
// Shared types and helpers for the OV7670 RGB565 -> RGB444 capture path.
// The optional freeze input is enabled with the CAPTURE_FREEZE_EN macro.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    S_WAIT_VS = 2'd0,
    S_BLANK   = 2'd1,
    S_ACTIVE  = 2'd2
  } cap_state_e;

  // MSB position of each RGB565 field; the top four bits of each are kept
  localparam int RGB565_R_MSB = 15;
  localparam int RGB565_G_MSB = 10;
  localparam int RGB565_B_MSB = 4;

  function automatic logic [11:0] rgb565_to_444(input logic [15:0] d);
    return {d[RGB565_R_MSB -: 4], d[RGB565_G_MSB -: 4], d[RGB565_B_MSB -: 4]};
  endfunction

endpackage

// File: rtl/cam_rgb444_capture_if.sv
// Camera byte bus in, frame-buffer write port out. Optional freeze input under
// CAPTURE_FREEZE_EN.
// Write port semantics: mem_we is a one-cycle strobe with no back-pressure; when
// it is high, mem_addr/mem_wdata are valid for exactly that cycle.
interface cam_rgb444_capture_if #(
  parameter int ADDR_W = 17
);
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_data;
`ifdef CAPTURE_FREEZE_EN
  logic              freeze;
`endif
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [11:0]       mem_wdata;
  logic              frame_done;
  logic              frame_err;

`ifdef CAPTURE_FREEZE_EN
  modport master (
    output cam_vsync, cam_href, cam_data, freeze,
    input  mem_we, mem_addr, mem_wdata, frame_done, frame_err
  );
  modport slave (
    input  cam_vsync, cam_href, cam_data, freeze,
    output mem_we, mem_addr, mem_wdata, frame_done, frame_err
  );
`else
  modport master (
    output cam_vsync, cam_href, cam_data,
    input  mem_we, mem_addr, mem_wdata, frame_done, frame_err
  );
  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output mem_we, mem_addr, mem_wdata, frame_done, frame_err
  );
`endif
endinterface

// File: rtl/cam_rgb444_capture_sync_edge.sv
// Registers the camera inputs once and derives single-cycle edge pulses from the
// registered copies.
module cam_sync_edge (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_vsync,
  input  logic       i_href,
  input  logic [7:0] i_data,
  output logic       o_vsync,
  output logic       o_href,
  output logic [7:0] o_data,
  output logic       o_vsync_rise,
  output logic       o_vsync_fall,
  output logic       o_href_fall
);
  logic       r_vsync;
  logic       r_vsync_d;
  logic       r_href;
  logic       r_href_d;
  logic [7:0] r_data;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_vsync   <= 1'b0;
      r_vsync_d <= 1'b0;
      r_href    <= 1'b0;
      r_href_d  <= 1'b0;
      r_data    <= 8'h00;
    end else begin
      r_vsync   <= i_vsync;
      r_vsync_d <= r_vsync;
      r_href    <= i_href;
      r_href_d  <= r_href;
      r_data    <= i_data;
    end
  end

  assign o_vsync      = r_vsync;
  assign o_href       = r_href;
  assign o_data       = r_data;
  assign o_vsync_rise = r_vsync & ~r_vsync_d;
  assign o_vsync_fall = ~r_vsync & r_vsync_d;
  assign o_href_fall  = ~r_href & r_href_d;

endmodule

// File: rtl/cam_rgb444_capture.sv
// OV7670 RGB565 byte-pair capture into an H_ACT x V_ACT RGB444 frame buffer.
// Define CAPTURE_FREEZE_EN to add a per-frame write freeze input.
module cam_rgb444_capture
  import cam_capture_pkg::*;
#(
  parameter int H_ACT  = 320,
  parameter int V_ACT  = 240,
  parameter int ADDR_W = 17
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cam_rgb444_capture_if.slave  bus,
  output cap_state_e           o_dbg_state
);
  localparam int LW = $clog2(V_ACT + 1);
  localparam int PW = $clog2(H_ACT + 1);
  localparam logic [LW-1:0]     V_MAX    = LW'(V_ACT);
  localparam logic [PW-1:0]     P_MAX    = PW'(H_ACT);
  localparam logic [ADDR_W-1:0] ADDR_ROW = ADDR_W'(H_ACT);

  logic       w_vsync, w_href, w_vsync_rise, w_vsync_fall, w_href_fall;
  logic [7:0] w_data;

  cam_sync_edge u_sync (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_vsync      (bus.cam_vsync),
    .i_href       (bus.cam_href),
    .i_data       (bus.cam_data),
    .o_vsync      (w_vsync),
    .o_href       (w_href),
    .o_data       (w_data),
    .o_vsync_rise (w_vsync_rise),
    .o_vsync_fall (w_vsync_fall),
    .o_href_fall  (w_href_fall)
  );

  cap_state_e        r_state, w_state_nx;
  logic [LW-1:0]     r_line_cnt, w_line_cnt_nx;
  logic [PW-1:0]     r_pix_cnt;
  logic              r_phase;
  logic [7:0]        r_hi;
  logic [ADDR_W-1:0] r_addr, r_line_base;
  logic              r_we, r_done, r_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [11:0]       r_wdata;
  logic              w_start, w_byte, w_line_end, w_line_inc, w_frame_end;
  logic              w_wr, w_frozen;

`ifdef CAPTURE_FREEZE_EN
  logic r_freeze;
  always_ff @(posedge clk) begin
    if (!reset_n)     r_freeze <= 1'b0;
    else if (w_start) r_freeze <= bus.freeze;
  end
  assign w_frozen = r_freeze;
`else
  assign w_frozen = 1'b0;
`endif

  always_comb begin
    w_state_nx    = r_state;
    w_start       = 1'b0;
    w_byte        = 1'b0;
    w_line_end    = 1'b0;
    w_line_inc    = 1'b0;
    w_frame_end   = 1'b0;
    w_line_cnt_nx = r_line_cnt;
    case (r_state)
      S_WAIT_VS: if (w_vsync) w_state_nx = S_BLANK;
      S_BLANK: begin
        if (w_vsync_fall) begin
          w_start    = 1'b1;
          w_state_nx = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        w_byte = w_href & ~w_vsync;
        // Line end is resolved first so a coincident vsync rise sees the final count
        if (w_href_fall) begin
          w_line_end    = 1'b1;
          w_line_inc    = (r_pix_cnt != '0) && (r_line_cnt != V_MAX);
          w_line_cnt_nx = r_line_cnt + LW'(w_line_inc);
        end
        if (w_vsync_rise) begin
          w_frame_end = 1'b1;
          w_state_nx  = S_BLANK;
        end
      end
      default: w_state_nx = S_WAIT_VS;
    endcase
    w_wr = w_byte & r_phase & ~w_frozen & (r_pix_cnt < P_MAX) & (r_line_cnt < V_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_WAIT_VS;
      r_line_cnt  <= '0;
      r_pix_cnt   <= '0;
      r_phase     <= 1'b0;
      r_hi        <= 8'h00;
      r_addr      <= '0;
      r_line_base <= '0;
      r_we        <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_wdata     <= 12'h000;
    end else begin
      r_state <= w_state_nx;
      r_we    <= w_wr;
      r_done  <= w_frame_end && (w_line_cnt_nx == V_MAX);
      if (w_frame_end && (w_line_cnt_nx != V_MAX)) r_err <= 1'b1;
      if (w_wr) begin
        r_mem_addr <= r_addr;
        r_wdata    <= rgb565_to_444({r_hi, w_data});
      end
      if (w_start) begin
        r_line_cnt  <= '0;
        r_pix_cnt   <= '0;
        r_phase     <= 1'b0;
        r_addr      <= '0;
        r_line_base <= '0;
      end else if (w_line_end) begin
        // Jump to the next row start so short lines leave a gap
        r_line_cnt <= w_line_cnt_nx;
        r_pix_cnt  <= '0;
        r_phase    <= 1'b0;
        if (w_line_inc) begin
          r_line_base <= r_line_base + ADDR_ROW;
          r_addr      <= r_line_base + ADDR_ROW;
        end else begin
          r_addr <= r_line_base;
        end
      end else if (w_byte) begin
        if (!r_phase) begin
          r_hi    <= w_data;
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          if (r_pix_cnt != P_MAX) begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
            r_addr    <= r_addr + 1'b1;
          end
        end
      end
    end
  end

  assign bus.mem_we     = r_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.frame_done = r_done;
  assign bus.frame_err  = r_err;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_cam_rgb444_capture.sv
// Randomized scoreboard bench for cam_rgb444_capture with a frame-level model.
module tb_cam_rgb444_capture;
  import cam_capture_pkg::*;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 17;
  localparam int EW = 1 + 32 + AW + 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  cap_state_e dbg_state;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cam_rgb444_capture_if #(.ADDR_W(AW)) bus();

  cam_rgb444_capture #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit m_active = 0;
  bit m_seen_vs = 0;
  bit m_err = 0;
  int m_line = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Keep the top 4 bits of each 5/6/5 field
  function automatic logic [11:0] ref_444(input int w);
    int r4, g4, b4;
    r4 = ((w / 2048) % 32) / 2;
    g4 = ((w / 32) % 64) / 4;
    b4 = (w % 32) / 2;
    return 12'(r4 * 256 + g4 * 16 + b4);
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    #1;
    if (reset_n) begin
      if (bus.mem_we && bus.frame_done) chk("we_done_overlap", 1, 0);
      if (bus.mem_we || bus.frame_done) begin
        a = bus.frame_done ? {1'b1, 32'(cyc), AW'(0), 12'h000}
                           : {1'b0, 32'(cyc), bus.mem_addr, bus.mem_wdata};
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 64'(a), 0);
        end else begin
          e = exp_q.pop_front();
          chk(bus.frame_done ? "frame_done" : "write", 64'(a), 64'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit h, input logic [7:0] d);
    @(negedge clk);
    bus.cam_vsync = v;
    bus.cam_href  = h;
    bus.cam_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(bus.cam_vsync, 1'b0, 8'h00);
  endtask

  task automatic vsync_high(input int n);
    drive(1'b1, 1'b0, 8'h00);
    if (m_active) begin
      if (m_line == V) exp_q.push_back({1'b1, 32'(cyc + 2), AW'(0), 12'h000});
      else m_err = 1'b1;
      m_active = 1'b0;
    end
    m_seen_vs = 1'b1;
    repeat (n - 1) drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic vsync_low(input int n);
    drive(1'b0, 1'b0, 8'h00);
    if (m_seen_vs) begin
      m_active = 1'b1;
      m_line   = 0;
    end
    repeat (n - 1) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int npix, input bit odd, input int gap,
                           input logic [15:0] fixed, input bit rnd);
    logic [15:0] w;
    for (int p = 0; p < npix; p++) begin
      w = rnd ? 16'($urandom_range(0, 65535)) : fixed;
      drive(1'b0, 1'b1, w[15:8]);
      drive(1'b0, 1'b1, w[7:0]);
      if (m_active && m_line < V && p < H)
        exp_q.push_back({1'b0, 32'(cyc + 2), AW'(m_line * H + p), ref_444(int'(w))});
    end
    if (odd) drive(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 8'h00);
    if (m_active && npix > 0 && m_line < V) m_line++;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 0);
    idle(2);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"},    64'(bus.mem_we), 0);
    chk({tag, "_done"},  64'(bus.frame_done), 0);
    chk({tag, "_err"},   64'(bus.frame_err), 0);
    chk({tag, "_addr"},  64'(bus.mem_addr), 0);
    chk({tag, "_wdata"}, 64'(bus.mem_wdata), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nl;
    bus.cam_vsync = 1'b0;
    bus.cam_href  = 1'b0;
    bus.cam_data  = 8'h00;
`ifdef CAPTURE_FREEZE_EN
    bus.freeze    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_zero("reset");
    chk("reset_state", 64'(dbg_state), 64'(S_WAIT_VS));
    reset_n = 1'b1;

    // Full frame of red pixels; last href fall coincides with vsync rise
    vsync_high(3);
    vsync_low(3);
    for (int l = 0; l < V; l++) send_line(H, 1'b0, (l == V - 1) ? 0 : 2, 16'hF800, 1'b0);
    vsync_high(3);
    wait_drain();
    chk("err_after_full", 64'(bus.frame_err), 64'(m_err));

    // Green, overlong blue line, short line with odd byte, random line
    vsync_low(3);
    send_line(H, 1'b0, 2, 16'h07E0, 1'b0);
    send_line(10, 1'b0, 2, 16'h001F, 1'b0);
    send_line(5, 1'b1, 2, 16'h0000, 1'b1);
    send_line(H, 1'b0, 1, 16'h0000, 1'b1);
    vsync_high(3);
    wait_drain();
    chk("err_after_mixed", 64'(bus.frame_err), 64'(m_err));

    // Short frame: two lines only
    vsync_low(3);
    send_line(H, 1'b0, 2, 16'h0000, 1'b1);
    send_line(H, 1'b0, 2, 16'h0000, 1'b1);
    vsync_high(3);
    wait_drain();
    chk("err_short_frame", 64'(bus.frame_err), 64'(m_err));

    // Following full frame restarts at address 0, error stays set
    vsync_low(2);
    for (int l = 0; l < V; l++) send_line(H, 1'b0, 1, 16'h0000, 1'b1);
    vsync_high(3);
    wait_drain();
    chk("err_sticky", 64'(bus.frame_err), 64'(m_err));

    // Random frames
    for (int f = 0; f < 6; f++) begin
      vsync_low($urandom_range(2, 4));
      nl = $urandom_range(0, 6);
      for (int l = 0; l < nl; l++)
        send_line($urandom_range(0, 11), 1'($urandom_range(0, 1)),
                  (l == nl - 1 && $urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3),
                  16'h0000, 1'b1);
      vsync_high($urandom_range(2, 4));
      wait_drain();
      chk("err_random", 64'(bus.frame_err), 64'(m_err));
    end

    // Reset in the middle of a line
    vsync_low(2);
    send_line(3, 1'b1, 0, 16'h0000, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    m_active = 1'b0;
    m_seen_vs = 1'b0;
    m_err = 1'b0;
    @(negedge clk);
    check_zero("midline_reset");
    bus.cam_href = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    send_line(H, 1'b0, 2, 16'h0000, 1'b1);
    vsync_low(2);
    send_line(H, 1'b0, 2, 16'h0000, 1'b1);
    idle(4);
    chk("no_capture_before_vs", 64'(exp_q.size()), 0);
    vsync_high(3);
    vsync_low(3);
    for (int l = 0; l < V; l++) send_line(H, 1'b0, 1, 16'h0000, 1'b1);
    vsync_high(3);
    wait_drain();
    chk("err_after_reset", 64'(bus.frame_err), 64'(m_err));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
